// File: rtl/tdm_demux1_4_pkg.sv
// rtl/tdm_demux1_4_pkg.sv - shared types and constants for the 1:4 TDM slot demux
package tdm_demux1_4_pkg;

  localparam int NUM_LANES = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_LANES - 1);

endpackage

// File: rtl/tdm_demux1_4_slot_tracker.sv
// rtl/tdm_demux1_4_slot_tracker.sv - lock state, slot counter and sync checking
module tdm_demux1_4_slot_tracker
  import tdm_demux1_4_pkg::*;
#(
  parameter int SYNC_EVERY_FRAME = 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  din_valid_i,
  input  logic  sync_i,
  output logic  capture_o,
  output slot_t cap_idx_o,
  output logic  frame_done_o,
  output logic  sync_err_o,
  output slot_t slot_o,
  output logic  locked_o
);

  state_e state_q, state_d;
  slot_t  slot_q, slot_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    capture_o    = 1'b0;
    cap_idx_o    = '0;
    frame_done_o = 1'b0;
    sync_err_o   = 1'b0;
    if (din_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (sync_i) begin
            capture_o = 1'b1;
            slot_d    = slot_t'(1);
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          // A sync always restarts the frame; it is only an error away from slot 0.
          if (sync_i) begin
            sync_err_o = (slot_q != '0);
            capture_o  = 1'b1;
            slot_d     = slot_t'(1);
          end else if (slot_q == '0) begin
            if (SYNC_EVERY_FRAME != 0) begin
              sync_err_o = 1'b1;
              state_d    = HUNT;
            end else begin
              capture_o = 1'b1;
              slot_d    = slot_t'(1);
            end
          end else if (slot_q == LAST_SLOT) begin
            frame_done_o = 1'b1;
            slot_d       = '0;
          end else begin
            capture_o = 1'b1;
            cap_idx_o = slot_q;
            slot_d    = slot_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign slot_o   = slot_q;
  assign locked_o = (state_q == LOCKED);

endmodule

// File: rtl/tdm_demux1_4.sv
// rtl/tdm_demux1_4.sv - 1:4 TDM demux: sync-aligned beats into a 4-lane frame
module tdm_demux1_4
  import tdm_demux1_4_pkg::*;
#(
  parameter int WIDTH            = 1,
  parameter int SYNC_EVERY_FRAME = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  input  logic                       sync,
  output logic [NUM_LANES*WIDTH-1:0] lane_out,
  output logic                       out_valid,
  output logic [SLOT_W-1:0]          slot,
  output logic                       locked,
  output logic                       sync_err
);

  logic  capture;
  slot_t cap_idx;
  logic  frame_done;
  logic  frame_err;

  // Slot 3 never needs a shadow: it goes straight into lane_out with the others.
  logic [NUM_LANES-2:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_LANES*WIDTH-1:0]      lane_out_q, lane_out_d;
  logic                            out_valid_q, sync_err_q;

  tdm_demux1_4_slot_tracker #(
    .SYNC_EVERY_FRAME(SYNC_EVERY_FRAME)
  ) u_slot_tracker (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .din_valid_i (din_valid),
    .sync_i      (sync),
    .capture_o   (capture),
    .cap_idx_o   (cap_idx),
    .frame_done_o(frame_done),
    .sync_err_o  (frame_err),
    .slot_o      (slot),
    .locked_o    (locked)
  );

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_LANES - 1; k++) begin
      if (capture && (cap_idx == slot_t'(k))) begin
        shadow_d[k] = din;
      end
    end
    lane_out_d = frame_done ? {din, shadow_q} : lane_out_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      lane_out_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      lane_out_q  <= lane_out_d;
      out_valid_q <= frame_done;
      sync_err_q  <= frame_err;
    end
  end

  assign lane_out  = lane_out_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux1_4.sv
// tb/tb_tdm_demux1_4.sv - scoreboard bench for three tdm_demux1_4 configurations
module tb_tdm_demux1_4;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic        sync;
  logic [31:0] lo0, lo1;
  logic [3:0]  lo2;
  logic [2:0]  ov, se, lk;
  logic [1:0]  sl [3];

  int n_checks = 0;
  int n_fail   = 0;

  int          m_cnt  [3];
  bit          m_lk   [3];
  logic [7:0]  m_fb   [3][4];
  logic [31:0] m_last [3];
  ev_t q0[$], q1[$], q2[$];
  ev_t mon_e;

  always #5 clk = ~clk;

  tdm_demux1_4 #(.WIDTH(8), .SYNC_EVERY_FRAME(1)) u_dut8s (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .lane_out(lo0), .out_valid(ov[0]), .slot(sl[0]), .locked(lk[0]), .sync_err(se[0]));

  tdm_demux1_4 #(.WIDTH(8), .SYNC_EVERY_FRAME(0)) u_dut8n (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .lane_out(lo1), .out_valid(ov[1]), .slot(sl[1]), .locked(lk[1]), .sync_err(se[1]));

  tdm_demux1_4 #(.WIDTH(1), .SYNC_EVERY_FRAME(1)) u_dut1s (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid), .sync(sync),
    .lane_out(lo2), .out_valid(ov[2]), .slot(sl[2]), .locked(lk[2]), .sync_err(se[2]));

  function automatic int wid(int i);
    return (i == 2) ? 1 : 8;
  endfunction

  function automatic bit sef(int i);
    return (i != 1);
  endfunction

  function automatic logic [31:0] lane(int i);
    case (i)
      0:       return lo0;
      1:       return lo1;
      default: return {28'b0, lo2};
    endcase
  endfunction

  function automatic void push_ev(int i, logic err, logic [31:0] data);
    ev_t e;
    e.err  = err;
    e.data = data;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsz(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ev_t qpop(int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Reference: collect beats of the current frame; publish when four are in hand.
  function automatic void model_step(int i, logic v, logic s, logic [7:0] d);
    logic [7:0]  dd;
    logic [31:0] f;
    if (!v) return;
    dd = (wid(i) == 1) ? {7'b0, d[0]} : d;
    if (!m_lk[i]) begin
      if (s) begin
        m_fb[i][0] = dd;
        m_cnt[i]   = 1;
        m_lk[i]    = 1'b1;
      end
      return;
    end
    if (s) begin
      if (m_cnt[i] != 0) push_ev(i, 1'b1, 32'h0);
      m_fb[i][0] = dd;
      m_cnt[i]   = 1;
      return;
    end
    if (m_cnt[i] == 0 && sef(i)) begin
      push_ev(i, 1'b1, 32'h0);
      m_lk[i] = 1'b0;
      return;
    end
    m_fb[i][m_cnt[i]] = dd;
    m_cnt[i]          = m_cnt[i] + 1;
    if (m_cnt[i] == 4) begin
      f = 32'h0;
      for (int k = 0; k < 4; k++) f = f | (32'(m_fb[i][k]) << (k * wid(i)));
      m_last[i] = f;
      push_ev(i, 1'b0, f);
      m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i]  = 0;
      m_lk[i]   = 1'b0;
      m_last[i] = 32'h0;
      for (int k = 0; k < 4; k++) m_fb[i][k] = 8'h0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_lane_out[%0d]", tag, i), lane(i), 32'h0);
      chk($sformatf("%s_strobes[%0d]", tag, i), {30'b0, ov[i], se[i]}, 32'h0);
      chk($sformatf("%s_locked_slot[%0d]", tag, i), {29'b0, lk[i], sl[i]}, 32'h0);
    end
  endtask

  task automatic beat(logic v, logic s, logic [7:0] d);
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, v, s, d);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) beat(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every strobe must match the next queued event; lane_out, slot, locked tracked each cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("lane_out_hold[%0d]", i), lane(i), m_last[i]);
        chk($sformatf("slot[%0d]", i), 32'(sl[i]), 32'(m_cnt[i]));
        chk($sformatf("locked[%0d]", i), 32'(lk[i]), 32'(m_lk[i]));
        chk($sformatf("ov_se_exclusive[%0d]", i), 32'(ov[i] & se[i]), 32'h0);
        chk($sformatf("strobe_present[%0d]", i), 32'(ov[i] | se[i]), 32'(qsz(i) != 0));
        if ((ov[i] | se[i]) && qsz(i) != 0) begin
          mon_e = qpop(i);
          chk($sformatf("strobe_kind[%0d]", i), {30'b0, ov[i], se[i]}, {30'b0, ~mon_e.err, mon_e.err});
          if (!mon_e.err) chk($sformatf("frame_data[%0d]", i), lane(i), mon_e.data);
        end
      end
    end
  end

  initial begin
    logic s;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = 8'h0;
    model_reset();
    #1;
    chk_reset_outputs("power_on_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Acquire: 1(sync),0,1,1 -> 4'b1101
    beat(1'b1, 1'b1, 8'd1);
    chk("acquire_locked", 32'(lk[2]), 32'h1);
    beat(1'b1, 1'b0, 8'd0);
    beat(1'b1, 1'b0, 8'd1);
    beat(1'b1, 1'b0, 8'd1);
    chk("acquire_out_valid", 32'(ov[2]), 32'h1);
    chk("acquire_lane_w1", {28'b0, lo2}, 32'h0000000D);
    chk("acquire_lane_w8", lo0, 32'h01010001);

    // Gapped input, same frame
    beat(1'b1, 1'b1, 8'd1); idle(2);
    beat(1'b1, 1'b0, 8'd0); idle(2);
    beat(1'b1, 1'b0, 8'd1); idle(2);
    chk("gapped_slot", 32'(sl[2]), 32'h3);
    beat(1'b1, 1'b0, 8'd1);
    chk("gapped_lane_w1", {28'b0, lo2}, 32'h0000000D);
    idle(2);

    // Early sync on slot 2
    beat(1'b1, 1'b1, 8'd1); beat(1'b1, 1'b0, 8'd1);
    beat(1'b1, 1'b0, 8'd0); beat(1'b1, 1'b0, 8'd0);
    chk("pre_early_lane_w1", {28'b0, lo2}, 32'h00000003);
    beat(1'b1, 1'b1, 8'd1); beat(1'b1, 1'b0, 8'd0);
    beat(1'b1, 1'b1, 8'd1);
    chk("early_sync_err", {30'b0, ov[2], se[2]}, 32'h1);
    chk("early_lane_kept", {28'b0, lo2}, 32'h00000003);
    beat(1'b1, 1'b0, 8'd1); beat(1'b1, 1'b0, 8'd1); beat(1'b1, 1'b0, 8'd0);
    chk("early_lane_w1", {28'b0, lo2}, 32'h00000007);

    // Missing sync at slot 0
    beat(1'b1, 1'b0, 8'd1);
    chk("missing_sync_strict", {29'b0, se[0], lk[0], se[2]}, 32'h5);
    chk("missing_sync_relaxed", {30'b0, se[1], lk[1]}, 32'h1);
    beat(1'b1, 1'b0, 8'd0); beat(1'b1, 1'b0, 8'd1); beat(1'b1, 1'b0, 8'd1);
    chk("relaxed_frame", {31'b0, ov[1]}, 32'h1);
    chk("relaxed_lane", lo1, 32'h01010001);
    chk("strict_still_hunting", {30'b0, lk[0], ov[0]}, 32'h0);

    // Streaming 0x00..0x0B
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) beat(1'b1, k == 0, 8'(f * 4 + k));
      chk($sformatf("stream_lane_%0d", f), lo0,
          {8'(f * 4 + 3), 8'(f * 4 + 2), 8'(f * 4 + 1), 8'(f * 4)});
    end

    // Reset mid-frame
    beat(1'b1, 1'b1, 8'h55);
    beat(1'b1, 1'b0, 8'h66);
    do_reset();

    // Randomized traffic with occasional sync faults and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        if (m_cnt[0] == 0) s = ($urandom_range(0, 7) != 0);
        else               s = ($urandom_range(0, 11) == 0);
        beat($urandom_range(0, 3) != 0, s, 8'($urandom));
      end
    end
    idle(3);
    for (int i = 0; i < 3; i++) chk($sformatf("queue_drained[%0d]", i), 32'(qsz(i)), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
